led_pattern_ctrl: RTL and testbench

//  Consumer of the 100 Hz divider output. Single clk domain: clk_100Hz is sampled as data and turned into
//  a one-cycle tick. Debounces two push-buttons on that tick and runs an LED pattern engine
//  (4 modes, pause, 4 speeds) that drives the board LEDs.

---
 rtl/led_pattern_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - clk_100Hz tick generator, button debouncers and LED pattern engine

// Turns the asynchronous clk_100Hz level into a one-clk pulse per rising edge.
// rise is the combinational edge strobe that qualifies all state updates;
// tick is its registered copy, so outputs and tick change on the same edge.
module lpc_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic tick
);

  logic s1;
  logic s2;
  logic prev;

  assign rise = s2 & ~prev;

  // two-flop synchronizer, previous-value flop and registered tick pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      tick <= s2 & ~prev;
    end
  end

endmodule

// Debounces one active-high push-button, sampling only when sample_en is high.
// press is combinational and asserts on the sampling cycle that accepts a
// 0->1 level change, so the consumer acts on the same edge that flips stable.
module lpc_debounce #(
  parameter int DEB_TICKS = 3,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic sample_en,
  output logic press
);

  logic             b1;
  logic             b2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             at_limit;

  assign differs  = (b2 != stable);
  assign at_limit = (cnt == CNT_W'(DEB_TICKS - 1));
  assign press    = sample_en & differs & at_limit & b2;

  // synchronize the raw button and count consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b1     <= 1'b0;
      b2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      b1 <= btn;
      b2 <= b1;
      if (sample_en) begin
        if (differs) begin
          if (at_limit) begin
            stable <= b2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// LED pattern engine: four modes, pause toggle and four step speeds.
module led_pattern_ctrl #(
  parameter int STEP_TICKS = 25,
  parameter int DEB_TICKS  = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_100Hz,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic [1:0] sw_speed,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       tick
);

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ROT_L = 2'd0;
  localparam logic [1:0] MODE_ROT_R = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_FILL  = 2'd3;

  state_t           state;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_limit;
  logic             step_due;
  logic             rise;
  logic             mode_press;
  logic             pause_press;
  logic [1:0]       next_mode;

  function automatic logic [7:0] init_led(input logic [1:0] m);
    case (m)
      MODE_ROT_L: init_led = 8'h01;
      MODE_ROT_R: init_led = 8'h80;
      default:    init_led = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] advance_led(input logic [1:0] m, input logic [7:0] cur);
    case (m)
      MODE_ROT_L: advance_led = {cur[6:0], cur[7]};
      MODE_ROT_R: advance_led = {cur[0], cur[7:1]};
      MODE_BLINK: advance_led = ~cur;
      MODE_FILL:  advance_led = (cur == 8'hFF) ? 8'h00 : {cur[6:0], 1'b1};
      default:    advance_led = cur;
    endcase
  endfunction

  lpc_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clk_100Hz),
    .rise  (rise),
    .tick  (tick)
  );

  lpc_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb_mode (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn_mode),
    .sample_en (rise),
    .press     (mode_press)
  );

  lpc_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb_pause (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn_pause),
    .sample_en (rise),
    .press     (pause_press)
  );

  // step period follows sw_speed live; '>=' lets a slower-to-faster change step at once
  always_comb begin
    step_limit = CNT_W'(STEP_TICKS * (int'(sw_speed) + 1) - 1);
    step_due   = (step_cnt >= step_limit);
    next_mode  = mode + 2'd1;
  end

  // RUN/PAUSE state, mode, step counter and LED pattern, all updated on tick only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      paused   <= 1'b0;
      mode     <= MODE_ROT_L;
      led      <= 8'h01;
      step_cnt <= '0;
    end else if (rise) begin
      if (pause_press) begin
        case (state)
          RUN: begin
            state  <= PAUSE;
            paused <= 1'b1;
          end
          default: begin
            state  <= RUN;
            paused <= 1'b0;
          end
        endcase
      end
      // a mode press wins over a due step; a pause press in either direction skips counting
      if (mode_press) begin
        mode     <= next_mode;
        led      <= init_led(next_mode);
        step_cnt <= '0;
      end else if (state == RUN && !pause_press) begin
        if (step_due) begin
          step_cnt <= '0;
          led      <= advance_led(mode, led);
        end else begin
          step_cnt <= step_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl
module tb_led_pattern_ctrl;

  localparam int STEP_TICKS = 2;
  localparam int DEB_TICKS  = 3;
  localparam int CNT_W      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_100Hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_pause = 1'b0;
  logic [1:0] sw_speed = 2'd0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;
  bit gen_on   = 1'b0;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] mode;
    logic       paused;
  } exp_t;

  exp_t exp_q[$];

  // reference state, one update per tick
  logic [7:0] m_led;
  logic [1:0] m_mode;
  logic       m_paused;
  int         m_step;
  logic       m_st_mode, m_st_pause;
  int         m_cnt_mode, m_cnt_pause;

  led_pattern_ctrl #(.STEP_TICKS(STEP_TICKS), .DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_100Hz (clk_100Hz),
    .btn_mode  (btn_mode),
    .btn_pause (btn_pause),
    .sw_speed  (sw_speed),
    .led       (led),
    .mode      (mode),
    .paused    (paused),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  initial begin
    wait (gen_on);
    forever begin
      repeat (5) @(posedge clk);
      #1 clk_100Hz = ~clk_100Hz;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_init(input logic [1:0] md);
    case (md)
      2'd0:    return 8'h01;
      2'd1:    return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] model_adv(input logic [1:0] md, input logic [7:0] l);
    logic [7:0] r;
    case (md)
      2'd0:    r = (l << 1) | (l >> 7);
      2'd1:    r = (l >> 1) | (l << 7);
      2'd2:    r = l ^ 8'hFF;
      default: r = (l == 8'hFF) ? 8'h00 : ((l << 1) | 8'h01);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_led = 8'h01; m_mode = 2'd0; m_paused = 1'b0; m_step = 0;
    m_st_mode = 1'b0; m_st_pause = 1'b0; m_cnt_mode = 0; m_cnt_pause = 0;
  endtask

  task automatic model_deb(input logic s, inout logic st, inout int cnt, output logic pr);
    pr = 1'b0;
    if (s != st) begin
      if (cnt == DEB_TICKS - 1) begin
        st = s; cnt = 0; pr = s;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic model_step(input logic bm, input logic bp, input logic [1:0] spd);
    logic mp, pp;
    int lim;
    model_deb(bm, m_st_mode, m_cnt_mode, mp);
    model_deb(bp, m_st_pause, m_cnt_pause, pp);
    lim = STEP_TICKS * (int'(spd) + 1) - 1;
    if (mp) begin
      m_mode = m_mode + 2'd1;
      m_led  = model_init(m_mode);
      m_step = 0;
    end else if (!m_paused && !pp) begin
      if (m_step >= lim) begin
        m_step = 0;
        m_led  = model_adv(m_mode, m_led);
      end else begin
        m_step++;
      end
    end
    if (pp) m_paused = !m_paused;
  endtask

  task automatic push_expected();
    exp_t e;
    e.led = m_led; e.mode = m_mode; e.paused = m_paused;
    exp_q.push_back(e);
  endtask

  task automatic compare_popped();
    exp_t e;
    e = exp_q.pop_front();
    check($sformatf("led@%0d", tick_no), 32'(led), 32'(e.led));
    check($sformatf("mode@%0d", tick_no), 32'(mode), 32'(e.mode));
    check($sformatf("paused@%0d", tick_no), 32'(paused), 32'(e.paused));
  endtask

  task automatic run_tick(input logic bm, input logic bp, input logic [1:0] spd);
    bit got;
    btn_mode = bm; btn_pause = bp; sw_speed = spd;
    model_step(bm, bp, spd);
    push_expected();
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) begin
        got = 1'b1;
        break;
      end
    end
    tick_no++;
    check($sformatf("tick_seen@%0d", tick_no), 32'(got), 32'd1);
    if (got) compare_popped();
    else void'(exp_q.pop_front());
  endtask

  task automatic idle(input int n, input logic [1:0] spd);
    for (int i = 0; i < n; i++) run_tick(1'b0, 1'b0, spd);
  endtask

  task automatic press_btns(input logic bm, input logic bp, input logic [1:0] spd);
    for (int i = 0; i < DEB_TICKS; i++) run_tick(bm, bp, spd);
    for (int i = 0; i < DEB_TICKS; i++) run_tick(1'b0, 1'b0, spd);
  endtask

  initial begin
    logic [7:0] snap;
    bit seen;
    model_reset();

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h01);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    gen_on = 1'b1;

    // first tick latency: 3rd posedge after clk_100Hz rises, one clk wide
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk_100Hz) begin
        seen = 1'b1;
        break;
      end
    end
    check("clk_100Hz_rise", 32'(seen), 32'd1);
    model_step(1'b0, 1'b0, 2'd0);
    push_expected();
    @(negedge clk); check("tick_lat1", 32'(tick), 32'd0);
    @(negedge clk); check("tick_lat2", 32'(tick), 32'd0);
    @(negedge clk); check("tick_lat3", 32'(tick), 32'd1);
    tick_no++;
    compare_popped();
    @(negedge clk); check("tick_width", 32'(tick), 32'd0);

    // ROT_L at speed 0 then speed 3
    idle(16, 2'd0);
    check("rotl_wrap", 32'(led), 32'h01);
    idle(16, 2'd3);
    check("rotl_slow", 32'(led), 32'h04);

    // debounce: 2-tick glitch rejected, 3-tick press accepted exactly once
    run_tick(1'b1, 1'b0, 2'd0);
    run_tick(1'b1, 1'b0, 2'd0);
    idle(3, 2'd0);
    check("deb_short", 32'(mode), 32'd0);
    for (int i = 0; i < 3; i++) run_tick(1'b1, 1'b0, 2'd0);
    check("deb_mode", 32'(mode), 32'd1);
    check("deb_led", 32'(led), 32'h80);
    run_tick(1'b1, 1'b0, 2'd0);
    run_tick(1'b1, 1'b0, 2'd0);
    check("deb_single", 32'(mode), 32'd1);
    idle(3, 2'd0);

    // mode cycling and FILL sequence
    press_btns(1'b1, 1'b0, 2'd0);
    check("cyc_blink", 32'(mode), 32'd2);
    idle(4, 2'd0);
    press_btns(1'b1, 1'b0, 2'd0);
    check("cyc_fill", 32'(mode), 32'd3);
    idle(16, 2'd0);
    check("fill_wrap", 32'(led), 32'h00);
    press_btns(1'b1, 1'b0, 2'd0);
    check("cyc_rotl", 32'(mode), 32'd0);

    // pause freezes the pattern; mode press while paused reloads
    press_btns(1'b0, 1'b1, 2'd0);
    check("pause_on", 32'(paused), 32'd1);
    snap = m_led;
    idle(20, 2'd0);
    check("pause_frozen", 32'(led), 32'(snap));
    press_btns(1'b1, 1'b0, 2'd0);
    check("pause_mode", 32'(mode), 32'd1);
    check("pause_mode_led", 32'(led), 32'h80);
    check("pause_kept", 32'(paused), 32'd1);
    press_btns(1'b0, 1'b1, 2'd0);
    check("pause_off", 32'(paused), 32'd0);

    // speed 3 -> 0 with step_cnt at 5 steps on the next tick
    for (int i = 0; i < 20 && m_step != 5; i++) run_tick(1'b0, 1'b0, 2'd3);
    snap = m_led;
    run_tick(1'b0, 1'b0, 2'd0);
    check("speed_drop", 32'(led), 32'({snap[0], snap[7:1]}));

    // mode press landing on a due step loads the initial pattern only
    for (int i = 0; i < 4 && m_step != 1; i++) run_tick(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < DEB_TICKS; i++) run_tick(1'b1, 1'b0, 2'd0);
    check("due_mode", 32'(mode), 32'd2);
    check("due_led", 32'(led), 32'h00);
    idle(3, 2'd0);

    // simultaneous mode and pause presses both apply
    press_btns(1'b1, 1'b1, 2'd0);
    check("both_mode", 32'(mode), 32'd3);
    check("both_paused", 32'(paused), 32'd1);
    press_btns(1'b0, 1'b1, 2'd0);
    idle(5, 2'd0);

    // reset in the middle of FILL
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_led", 32'(led), 32'h01);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_paused", 32'(paused), 32'd0);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    idle(6, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
